// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding APB requester. Accepts one command at a
//               time, runs the SETUP/ACCESS handshake, supports completer
//               wait states, an optional ACCESS timeout, and reports one
//               completion pulse per transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // APB side
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    // completion report
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Wait counter only ever needs to reach TIMEOUT_CYCLES-1; with the
    // timeout disabled it simply wraps and is never compared.
    localparam int                 c_CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit                 c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      r_wait_cnt;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_timeout;
    logic                    w_cnt_inc;
    logic                    w_psel;
    logic                    w_penable;
    logic                    w_cmd_ready;

    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_rsp_timeout;

    // Ready only in IDLE and never while reset is asserted.
    assign w_cmd_ready = (r_state == IDLE) && presetn;

    // State register; reset forces IDLE, silently dropping any transfer.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and APB phase decode; pready wins over a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && w_cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_psel      = 1'b1;
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
                if (pready) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (c_TIMEOUT_EN && (r_wait_cnt == c_WAIT_LAST)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, wait counter and completion report registers.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_wait_cnt    <= '0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= w_done || w_timeout;
            if (w_accept) begin
                r_pwrite   <= cmd_write;
                r_paddr    <= cmd_addr;
                r_pwdata   <= cmd_write ? cmd_wdata : '0;
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                r_rsp_err     <= pslverr;
                r_rsp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign psel        = w_psel;
    assign penable     = w_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master
// Description : Scoreboard bench for apb_master. Stimulus pushes expected
//               completions computed from transfer-level rules; a monitor
//               pops and compares whenever the DUT reports a completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] pwdata;
        logic [DW-1:0] rdata;
        logic          err;
        logic          to;
        int            len;
        bit            chained;
    } exp_t;

    typedef struct {
        int            waits;
        logic [DW-1:0] rdata;
        logic          err;
    } cfg_t;

    logic          pclk      = 1'b0;
    logic          presetn   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata    = '0;
    logic          pready    = 1'b0;
    logic          pslverr   = 1'b0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    exp_t exp_q[$];
    cfg_t cfg_q[$];
    int   n_checks   = 0;
    int   n_errs     = 0;
    bit   chain_next = 1'b0;

    apb_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout)
    );

    always #5 pclk = ~pclk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_checks++;
        n_errs++;
        $display("FAIL %s", nm);
    endfunction

    // Transfer-level outcome: a completer that waits TO or more cycles is
    // cut off after TO ACCESS cycles; otherwise ACCESS lasts waits+1 cycles.
    function automatic exp_t model(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                                   input int waits, input logic [DW-1:0] rd, input logic er);
        exp_t e;
        e.write   = wr;
        e.addr    = ad;
        e.pwdata  = wr ? wd : '0;
        e.chained = 1'b0;
        if (waits >= TO) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.to    = 1'b1;
            e.len   = TO;
        end else begin
            e.rdata = wr ? '0 : rd;
            e.err   = er;
            e.to    = 1'b0;
            e.len   = waits + 1;
        end
        return e;
    endfunction

    // Present a command and hold it until accepted; keep=1 leaves cmd_valid
    // asserted so the next call forms a back-to-back pair.
    task automatic send(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] rd, input logic er, input bit keep);
        int   n;
        exp_t e;
        cfg_t c;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = ad;
        cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept_wait_expired");
            cmd_valid  = 1'b0;
            chain_next = 1'b0;
            return;
        end
        e         = model(wr, ad, wd, waits, rd, er);
        e.chained = chain_next;
        exp_q.push_back(e);
        c.waits = waits;
        c.rdata = rd;
        c.err   = er;
        cfg_q.push_back(c);
        @(negedge pclk);
        chain_next = keep;
        if (!keep) begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end
    endtask

    // Completer: drives pready after the configured number of wait cycles.
    initial begin
        cfg_t cur;
        int   acc_n;
        cur.waits = 0;
        cur.rdata = '0;
        cur.err   = 1'b0;
        acc_n     = 0;
        forever begin
            @(negedge pclk);
            if (psel && !penable) begin
                if (cfg_q.size() > 0) cur = cfg_q.pop_front();
                acc_n  = 0;
                pready = 1'b0;
            end else if (psel && penable) begin
                acc_n++;
                pready = (acc_n > cur.waits);
            end else begin
                pready = 1'b0;
            end
            if (pready) begin
                prdata  = cur.rdata;
                pslverr = cur.err;
            end else begin
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor / scoreboard: samples 1 time unit after each rising edge.
    initial begin
        int            cyc, setup_cyc, last_rsp_cyc, acc_cnt;
        bit            in_xfer;
        logic [AW-1:0] h_addr;
        logic [DW-1:0] h_wdata, h_rdata;
        logic          h_write, h_err, h_to;
        exp_t          e;
        cyc = 0; setup_cyc = 0; last_rsp_cyc = -10; acc_cnt = 0; in_xfer = 1'b0;
        h_addr = '0; h_wdata = '0; h_rdata = '0; h_write = 1'b0; h_err = 1'b0; h_to = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            cyc++;
            if (!presetn) begin
                chk("rst_psel", psel, 0);
                chk("rst_penable", penable, 0);
                chk("rst_cmd_ready", cmd_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_paddr", paddr, 0);
                chk("rst_pwrite", pwrite, 0);
                chk("rst_pwdata", pwdata, 0);
                chk("rst_rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, 0);
                h_addr = '0; h_wdata = '0; h_rdata = '0; h_write = 1'b0; h_err = 1'b0; h_to = 1'b0;
                in_xfer = 1'b0;
            end else begin
                chk("cmd_ready_vs_idle", cmd_ready, !psel);
                chk("penable_without_psel", penable & ~psel, 0);
                if (psel) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_transfer");
                    end else begin
                        if (!penable) begin
                            if (exp_q[0].chained) chk("b2b_gap", cyc - last_rsp_cyc, 1);
                            setup_cyc = cyc;
                            acc_cnt   = 0;
                            in_xfer   = 1'b1;
                            h_addr    = exp_q[0].addr;
                            h_write   = exp_q[0].write;
                            h_wdata   = exp_q[0].pwdata;
                        end else begin
                            acc_cnt++;
                            chk("access_after_setup", in_xfer, 1);
                        end
                        chk("paddr", paddr, exp_q[0].addr);
                        chk("pwrite", pwrite, exp_q[0].write);
                        chk("pwdata", pwdata, exp_q[0].pwdata);
                    end
                end else begin
                    chk("paddr_hold", paddr, h_addr);
                    chk("pwrite_hold", pwrite, h_write);
                    chk("pwdata_hold", pwdata, h_wdata);
                end
                if (rsp_valid) begin
                    chk("psel_on_rsp", psel, 0);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_rsp");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_timeout", rsp_timeout, e.to);
                        chk("access_len", acc_cnt, e.len);
                        chk("rsp_latency", cyc - setup_cyc, e.len + 1);
                        h_rdata = e.rdata;
                        h_err   = e.err;
                        h_to    = e.to;
                    end
                    last_rsp_cyc = cyc;
                    in_xfer      = 1'b0;
                end else begin
                    chk("rsp_rdata_hold", rsp_rdata, h_rdata);
                    chk("rsp_err_hold", rsp_err, h_err);
                    chk("rsp_timeout_hold", rsp_timeout, h_to);
                end
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        int n;
        presetn = 1'b0;
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        chk("ready_after_reset", cmd_ready, 1);

        // write, no waits
        send(1'b1, 32'h10, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 1'b0);
        repeat (4) @(negedge pclk);
        // read with two wait cycles
        send(1'b0, 32'h20, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
        repeat (6) @(negedge pclk);
        // completer error
        send(1'b0, 32'h24, 32'h0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        repeat (4) @(negedge pclk);
        // timeout: pready never rises
        send(1'b0, 32'h30, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 1'b0);
        repeat (8) @(negedge pclk);
        // pready on the last allowed cycle
        send(1'b1, 32'h34, 32'hCAFE_F00D, TO - 1, 32'h0, 1'b0, 1'b0);
        repeat (8) @(negedge pclk);
        // three back-to-back commands
        send(1'b1, 32'h40, 32'h1111_1111, 0, 32'h0, 1'b0, 1'b1);
        send(1'b0, 32'h44, 32'h0, 1, 32'h2222_2222, 1'b0, 1'b1);
        send(1'b1, 32'h48, 32'h3333_3333, 0, 32'h0, 1'b0, 1'b0);
        repeat (6) @(negedge pclk);

        // reset in the middle of ACCESS
        send(1'b0, 32'h50, 32'h0, 3, 32'h7777_7777, 1'b0, 1'b0);
        @(negedge pclk);
        @(negedge pclk);
        chk("in_access_before_reset", psel & penable, 1);
        presetn = 1'b0;
        @(negedge pclk);
        chk("mid_rst_psel", psel, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        presetn = 1'b1;
        @(negedge pclk);
        chk("mid_rst_ready_after_release", cmd_ready, 1);
        repeat (4) @(negedge pclk);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic          wr, er;
            logic [AW-1:0] ad;
            logic [DW-1:0] wd, rd;
            int            waits;
            bit            keep;
            wr    = 1'($urandom_range(0, 1));
            ad    = $urandom;
            wd    = $urandom;
            rd    = $urandom;
            er    = ($urandom_range(0, 3) == 0);
            waits = $urandom_range(0, 6);
            keep  = (i != 39) && ($urandom_range(0, 2) == 0);
            send(wr, ad, wd, waits, rd, er, keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge pclk);
            n++;
        end
        if (exp_q.size() > 0) fail_now("drain_wait_expired");
        repeat (3) @(negedge pclk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
